// File: rtl/rxll_frame_reader_if.sv
// ============================================================================
// Module      : rxll_frame_reader_if
// Description : FIFO read port and transport-layer stream of the RX frame reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rxll_frame_reader_if;
  logic [35:0] fifo_do;
  logic        fifo_empty;
  logic        fifo_eof_rdy;
  logic        fifo_rd_en;
  logic [31:0] trn_data;
  logic        trn_sof;
  logic        trn_eof;
  logic        trn_err;
  logic        trn_valid;
  logic        trn_ready;

  modport master (
    input  fifo_do, fifo_empty, fifo_eof_rdy, trn_ready,
    output fifo_rd_en, trn_data, trn_sof, trn_eof, trn_err, trn_valid
  );

  modport slave (
    output fifo_do, fifo_empty, fifo_eof_rdy, trn_ready,
    input  fifo_rd_en, trn_data, trn_sof, trn_eof, trn_err, trn_valid
  );
endinterface

`default_nettype wire

// File: rtl/rxll_frame_reader.sv
// ============================================================================
// Module      : rxll_frame_reader
// Description : Drains the link-layer RX FIFO, enforces SOF/EOF framing and
//               streams frames with length/error status to the transport layer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rxll_frame_reader #(
  parameter int C_MAX_WORDS   = 2049,
  parameter int C_LEN_W       = 12,
  parameter int C_CUT_THROUGH = 0
) (
  input  logic               rd_clk,
  input  logic               rst,
  rxll_frame_reader_if.master bus,
  output logic               frame_done,
  output logic [C_LEN_W-1:0] frame_len,
  output logic               frame_err,
  output logic [15:0]        drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [C_LEN_W-1:0] c_max_cnt = C_LEN_W'(C_MAX_WORDS);

  state_t r_state;
  state_t w_state_nxt;

  logic [C_LEN_W-1:0] r_cnt;
  logic [C_LEN_W-1:0] r_pend_len;
  logic               r_err;
  logic [31:0]        r_data;
  logic               r_sof;
  logic               r_eof;
  logic               r_terr;
  logic               r_valid;

  logic               w_pop;
  logic               w_xfer_pop;
  logic               w_drop_pop;
  logic               w_start;
  logic               w_accept;
  logic               w_head_eof;
  logic               w_last_word;
  logic               w_word_err;
  logic [C_LEN_W-1:0] w_cnt_inc;
  logic               w_unused_rsvd;

  assign w_head_eof    = bus.fifo_do[34];
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_last_word   = (w_cnt_inc == c_max_cnt);
  // A SOF bit after the first word is not a new frame; it marks this one bad.
  assign w_word_err    = bus.fifo_do[33] | (bus.fifo_do[32] & (r_cnt != '0));
  assign w_accept      = r_valid & bus.trn_ready;
  assign w_unused_rsvd = bus.fifo_do[35];

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.fifo_empty) begin
          if (bus.fifo_do[32]) begin
            if ((C_CUT_THROUGH != 0) || bus.fifo_eof_rdy) begin
              w_state_nxt = S_XFER;
              w_start     = 1'b1;
            end
          end else begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_XFER: begin
        if (!bus.fifo_empty && (!r_valid || bus.trn_ready)) begin
          w_pop = 1'b1;
          if (w_head_eof) begin
            w_state_nxt = S_IDLE;
          end else if (w_last_word) begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (!bus.fifo_empty) begin
          w_pop = 1'b1;
          if (w_head_eof) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) begin
      w_pop   = 1'b0;
      w_start = 1'b0;
    end
  end

  assign w_xfer_pop = w_pop && (r_state == S_XFER);
  assign w_drop_pop = w_pop && (r_state == S_DROP);

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_pend_len <= '0;
      r_err      <= 1'b0;
      r_data     <= '0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_terr     <= 1'b0;
      r_valid    <= 1'b0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      frame_err  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (w_start) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end
      if (w_xfer_pop) begin
        r_data  <= bus.fifo_do[31:0];
        r_sof   <= (r_cnt == '0);
        r_eof   <= w_head_eof | w_last_word;
        r_terr  <= r_err | w_word_err | (w_last_word & ~w_head_eof);
        r_valid <= 1'b1;
        r_cnt   <= w_cnt_inc;
        r_err   <= r_err | w_word_err;
        // Length travels with the EOF beat so a new frame may start under a stalled EOF.
        if (w_head_eof | w_last_word) begin
          r_pend_len <= w_cnt_inc;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_accept && r_eof) begin
        frame_done <= 1'b1;
        frame_len  <= r_pend_len;
        frame_err  <= r_terr;
      end
      if (w_drop_pop) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign bus.fifo_rd_en = w_pop;
  assign bus.trn_data   = r_data;
  assign bus.trn_sof    = r_sof;
  assign bus.trn_eof    = r_eof;
  assign bus.trn_err    = r_terr;
  assign bus.trn_valid  = r_valid;

endmodule

`default_nettype wire
